uart_rx_vote_sampler: RTL and testbench

- Parametrised UART RX oversampling/voting stage; successor of the fixed 3-sample data sampler.
- Sits between the RX edge/bit counter and the RX FSM/deserializer.
- Captures 1, 3 or 5 samples of rx_in around the bit centre, majority-votes them, and flags disagreement as noise.
- Adds a sample_valid strobe and configuration error detection that the previous sampler lacked.

---
 rtl/uart_rx_vote_sampler.sv | 100 ++++++++++
 tb/tb_uart_rx_vote_sampler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_vote_sampler.sv
// uart_rx_vote_sampler: 1/3/5-sample majority-vote RX bit sampler; RX_SYNC_EN adds a 2-flop rx_in synchronizer
module uart_rx_vote_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  sample_data_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            sample_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);
  typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_t;
  state_t state, state_nxt;
  logic rx_s;
  logic [MAX_SAMPLES-1:0] samples;
  logic [2:0] n_req, n_mode, n_allow, n_q, ones;
  logic [1:0] h;
  logic [PRESCALE_W-1:0] c, first_pt, last_q, next_q;
  logic cap, start, vote;
`ifdef RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx_in};
  assign rx_s = sync[1];
`else
  assign rx_s = rx_in;
`endif
  assign n_mode   = sample_mode == 2'b00 ? 3'd1 : (sample_mode == 2'b10 && MAX_SAMPLES == 5) ? 3'd5 : 3'd3;
  assign n_allow  = prescale < PRESCALE_W'(8) ? 3'd1 : prescale < PRESCALE_W'(16) ? 3'd3 : 3'(MAX_SAMPLES);
  assign n_req    = n_mode < n_allow ? n_mode : n_allow;
  assign h        = 2'((n_req - 3'd1) >> 1);
  assign c        = (prescale >> 1) - PRESCALE_W'(1);
  assign first_pt = c - PRESCALE_W'(h);
  always_comb begin
    ones = '0;
    for (int i = 0; i < MAX_SAMPLES; i++)
      if (i < int'(n_q)) ones = ones + 3'(samples[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    cap = 1'b0;
    start = 1'b0;
    vote = 1'b0;
    if (cfg_err) state_nxt = IDLE;
    else
      case (state)
        IDLE:
          if (sample_data_en && edge_cnt == first_pt) begin
            start = 1'b1;
            cap = 1'b1;
            state_nxt = n_req == 3'd1 ? VOTE : COLLECT;
          end
        COLLECT:
          if (!sample_data_en) state_nxt = IDLE;
          else if (edge_cnt == next_q) begin
            cap = 1'b1;
            state_nxt = edge_cnt == last_q ? VOTE : COLLECT;
          end else if (edge_cnt == '0) state_nxt = IDLE;
        VOTE: begin
          vote = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      samples <= '1;
      n_q <= 3'd1;
      last_q <= '0;
      next_q <= '0;
      sampled_bit <= 1'b1;
      sample_valid <= 1'b0;
      noise_flag <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (prescale < PRESCALE_W'(4)) | prescale[0];
      sample_valid <= vote;
      if (cap) samples <= {samples[MAX_SAMPLES-2:0], rx_s};
      if (start) begin
        n_q <= n_req;
        last_q <= c + PRESCALE_W'(h);
        next_q <= first_pt + PRESCALE_W'(1);
      end else if (cap) next_q <= next_q + PRESCALE_W'(1);
      if (vote) begin
        sampled_bit <= ones > (n_q >> 1);
        noise_flag <= ones != 3'd0 && ones != n_q;
      end
    end
endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// tb_uart_rx_vote_sampler: directed table-driven bench for uart_rx_vote_sampler
module tb_uart_rx_vote_sampler;
  logic clk = 1'b0;
  logic rst, rx_in, sample_data_en;
  logic [5:0] edge_cnt, prescale;
  logic [1:0] sample_mode;
  logic sampled_bit, sample_valid, noise_flag, cfg_err;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  uart_rx_vote_sampler dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .sample_data_en(sample_data_en),
    .edge_cnt(edge_cnt), .prescale(prescale), .sample_mode(sample_mode),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid),
    .noise_flag(noise_flag), .cfg_err(cfg_err)
  );
  typedef struct {
    int ps;
    logic [1:0] md;
    logic [31:0] pat;
    int drop;
    int bit_e;
    int noise_e;
    int cnt_e;
    int at_e;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_bit(input int ps, input logic [1:0] md, input logic [31:0] pat, input int drop,
                         output int cnt, output int at);
    cnt = 0;
    at = -1;
    prescale = 6'(ps);
    sample_mode = md;
    for (int i = 0; i < ps + 3; i++) begin
      edge_cnt = i < ps ? 6'(i) : 6'd0;
      rx_in = i < ps ? pat[i] : 1'b1;
      sample_data_en = (i < ps) && (i < drop);
      @(posedge clk);
      #1;
      if (sample_valid) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
  endtask
  initial begin
    int cnt, at;
    v[0] = '{8,  2'b01, 32'h0000_0000, 99, 0, 0, 1, 5};
    v[1] = '{16, 2'b10, 32'h0000_FFBF, 99, 1, 1, 1, 10};
    v[2] = '{4,  2'b10, 32'h0000_000D, 99, 0, 0, 1, 2};
    v[3] = '{8,  2'b01, 32'h0000_00FF, 3,  0, 0, 0, -1};
    v[4] = '{8,  2'b00, 32'h0000_0008, 99, 1, 0, 1, 4};
    v[5] = '{16, 2'b01, 32'h0000_FEBF, 99, 0, 1, 1, 9};
    v[6] = '{16, 2'b11, 32'h0000_00C0, 99, 1, 1, 1, 9};
    v[7] = '{32, 2'b10, 32'h0000_6000, 99, 0, 1, 1, 18};
    v[8] = '{12, 2'b10, 32'h0000_0FFF, 99, 1, 0, 1, 7};
    v[9] = '{6,  2'b01, 32'h0000_003B, 99, 0, 0, 1, 3};
    rst = 1'b1;
    rx_in = 1'b1;
    sample_data_en = 1'b0;
    edge_cnt = '0;
    prescale = 6'd8;
    sample_mode = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sampled_bit", int'(sampled_bit), 1);
    chk("reset sample_valid", int'(sample_valid), 0);
    chk("reset noise_flag", int'(noise_flag), 0);
    chk("reset cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      run_bit(v[k].ps, v[k].md, v[k].pat, v[k].drop, cnt, at);
      chk($sformatf("vec%0d valid_count", k), cnt, v[k].cnt_e);
      if (v[k].cnt_e > 0) chk($sformatf("vec%0d valid_at", k), at, v[k].at_e);
      chk($sformatf("vec%0d sampled_bit", k), int'(sampled_bit), v[k].bit_e);
      chk($sformatf("vec%0d noise_flag", k), int'(noise_flag), v[k].noise_e);
    end
    prescale = 6'd5;
    edge_cnt = 6'd7;
    sample_data_en = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    chk("cfg_err odd prescale", int'(cfg_err), 1);
    prescale = 6'd2;
    @(posedge clk);
    #1;
    chk("cfg_err small prescale", int'(cfg_err), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      edge_cnt = 6'(i % 8);
      @(posedge clk);
      #1;
      if (sample_valid) cnt++;
    end
    chk("cfg_err blocked valids", cnt, 0);
    chk("cfg_err sampled_bit held", int'(sampled_bit), 0);
    prescale = 6'd8;
    edge_cnt = 6'd7;
    @(posedge clk);
    #1;
    chk("cfg_err cleared", int'(cfg_err), 0);
    sample_data_en = 1'b0;
    @(posedge clk);
    #1;
    sample_mode = 2'b01;
    rx_in = 1'b0;
    sample_data_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_cnt = 6'(i);
      @(posedge clk);
      #1;
    end
    edge_cnt = 6'd3;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst sampled_bit", int'(sampled_bit), 1);
    chk("midrst sample_valid", int'(sample_valid), 0);
    chk("midrst noise_flag", int'(noise_flag), 0);
    chk("midrst cfg_err", int'(cfg_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_data_en = 1'b0;
    edge_cnt = '0;
    @(posedge clk);
    #1;
    run_bit(8, 2'b01, 32'h0, 99, cnt, at);
    chk("post-reset valid_count", cnt, 1);
    chk("post-reset valid_at", at, 5);
    chk("post-reset sampled_bit", int'(sampled_bit), 0);
    chk("post-reset noise_flag", int'(noise_flag), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
